// File: rtl/btb_update_sched_pkg.sv
// Shared types for the BTB write-port scheduler and its update FIFO.
package btb_update_sched_pkg;

    // One BTB write: tag/PC and target.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
    } btb_upd_t;

    typedef enum logic {
        BS_IDLE,
        BS_SWEEP
    } btb_sched_state_e;

    // Low PC bits of an invalidation sentinel; fetch PCs are word aligned,
    // so an entry tagged with this pattern can never hit.
    localparam logic [1:0] BTB_INV_LSB = 2'b01;

endpackage

// File: rtl/btb_update_sched_fifo.sv
// Small resolve-update FIFO; pointers carry an extra wrap bit so full and
// empty are distinguished without a separate counter.
module btb_upd_fifo
    import btb_update_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_clear,
    input  logic     i_push,
    input  btb_upd_t i_data,
    input  logic     i_pop,
    output btb_upd_t o_head,
    output logic     o_full,
    output logic     o_empty
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0] r_wr;
    logic [PW:0] r_rd;
    btb_upd_t    r_mem [DEPTH];
    logic        w_push;
    logic        w_pop;

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[PW] != r_rd[PW]) && (r_wr[PW-1:0] == r_rd[PW-1:0]);
    assign w_push  = i_push && !o_full && !i_clear;
    assign w_pop   = i_pop && !o_empty && !i_clear;
    assign o_head  = r_mem[r_rd[PW-1:0]];

    // Pointer update; clear discards everything queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (i_clear) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + {{PW{1'b0}}, 1'b1};
            if (w_pop)  r_rd <= r_rd + {{PW{1'b0}}, 1'b1};
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr[PW-1:0]] <= i_data;
    end

endmodule

// File: rtl/btb_update_sched.sv
// Sole owner of the BTB write port: arbitrates buffered branch-resolution
// updates against debug writes, and runs the invalidate-all sweep.
module btb_update_sched
    import btb_update_sched_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rs_valid,
    input  logic        rs_taken,
    input  logic [31:0] rs_pc,
    input  logic [31:0] rs_target,
    input  logic        dbg_valid,
    output logic        dbg_ready,
    input  logic [31:0] dbg_pc,
    input  logic [31:0] dbg_target,
    input  logic        flush_req,
    output logic        btb_update,
    output logic [31:0] btb_pc_u,
    output logic [31:0] btb_target_u,
    output logic        sweep_busy,
    output logic        sweep_done,
    output logic [15:0] drop_cnt
);
    localparam int IDXW = $clog2(ENTRIES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ENTRIES - 1);
    localparam logic [IDXW-1:0] ONE_IDX  = IDXW'(1);

    btb_sched_state_e r_state;
    logic [IDXW-1:0]  r_idx;        // next sweep index to write
    logic             r_rr_dbg;     // 1: debug has priority on a tie
    logic             r_upd;
    logic [31:0]      r_pc_u;
    logic [31:0]      r_tgt_u;
    logic             r_busy;
    logic             r_done;
    logic [15:0]      r_drop;

    btb_upd_t         w_head;
    btb_upd_t         w_push_data;
    logic             w_full;
    logic             w_empty;
    logic             w_take;
    logic             w_push;
    logic             w_drop;
    logic             w_idle;
    logic             w_gnt_dbg;
    logic             w_gnt_fifo;
    logic             w_sweep_wr;
    logic             w_last;
    logic [IDXW-1:0]  w_sweep_idx;
    logic [31:0]      w_inv_pc;

    // A flush discards the same-cycle resolve entirely, so it is neither
    // queued nor counted; otherwise fullness is judged before any pop.
    assign w_take      = rs_valid && rs_taken && !flush_req;
    assign w_push      = w_take && !w_full;
    assign w_drop      = w_take && w_full;
    assign w_push_data = '{pc: rs_pc, target: rs_target};

    // Round-robin between the FIFO head and debug; flush always wins.
    assign w_idle     = (r_state == BS_IDLE) && !flush_req;
    assign w_gnt_dbg  = w_idle && dbg_valid && (w_empty || r_rr_dbg);
    assign w_gnt_fifo = w_idle && !w_empty && (!dbg_valid || !r_rr_dbg);
    assign dbg_ready  = w_gnt_dbg;

    // The flush cycle itself issues sentinel 0, so the sweep spans exactly
    // ENTRIES visible writes starting the cycle after flush_req.
    assign w_sweep_wr  = flush_req || (r_state == BS_SWEEP);
    assign w_sweep_idx = flush_req ? '0 : r_idx;
    assign w_last      = !flush_req && (r_state == BS_SWEEP) && (r_idx == LAST_IDX);

    // Misaligned sentinel PC targeting entry w_sweep_idx.
    always_comb begin
        w_inv_pc = '0;
        w_inv_pc[IDXW+1:0] = {w_sweep_idx, BTB_INV_LSB};
    end

    btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (flush_req),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_gnt_fifo),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Sweep FSM plus the registered BTB write port it drives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= BS_IDLE;
            r_idx    <= '0;
            r_rr_dbg <= 1'b0;
            r_upd    <= 1'b0;
            r_pc_u   <= '0;
            r_tgt_u  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_upd  <= w_sweep_wr || w_gnt_dbg || w_gnt_fifo;
            r_busy <= w_sweep_wr;
            r_done <= w_last;
            if (w_sweep_wr) begin
                r_pc_u  <= w_inv_pc;
                r_tgt_u <= '0;
            end else if (w_gnt_dbg) begin
                r_pc_u  <= dbg_pc;
                r_tgt_u <= dbg_target;
            end else if (w_gnt_fifo) begin
                r_pc_u  <= w_head.pc;
                r_tgt_u <= w_head.target;
            end
            if (w_gnt_dbg)  r_rr_dbg <= 1'b0;
            if (w_gnt_fifo) r_rr_dbg <= 1'b1;
            if (flush_req) begin
                r_state <= BS_SWEEP;
                r_idx   <= ONE_IDX;
            end else if (r_state == BS_SWEEP) begin
                r_idx <= r_idx + ONE_IDX;
                if (w_last) r_state <= BS_IDLE;
            end
        end
    end

    // Saturating count of resolves lost to a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         r_drop <= '0;
        else if (w_drop && r_drop != '1)    r_drop <= r_drop + 16'd1;
    end

    assign btb_update   = r_upd;
    assign btb_pc_u     = r_pc_u;
    assign btb_target_u = r_tgt_u;
    assign sweep_busy   = r_busy;
    assign sweep_done   = r_done;
    assign drop_cnt     = r_drop;

endmodule

// File: tb/tb_btb_update_sched.sv
// Directed bench for btb_update_sched: a queue-level reference model checked
// every cycle, plus literal expectations on the write log.
module tb_btb_update_sched;
    localparam int ENTRIES = 64;
    localparam int DEPTH   = 4;
    localparam int IDXW    = $clog2(ENTRIES);

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rs_valid = 1'b0, rs_taken = 1'b0;
    logic [31:0] rs_pc = '0, rs_target = '0;
    logic        dbg_valid = 1'b0;
    logic        dbg_ready;
    logic [31:0] dbg_pc = '0, dbg_target = '0;
    logic        flush_req = 1'b0;
    logic        btb_update;
    logic [31:0] btb_pc_u, btb_target_u;
    logic        sweep_busy, sweep_done;
    logic [15:0] drop_cnt;

    btb_update_sched #(.ENTRIES(ENTRIES), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_valid(rs_valid), .rs_taken(rs_taken), .rs_pc(rs_pc), .rs_target(rs_target),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_pc(dbg_pc), .dbg_target(dbg_target),
        .flush_req(flush_req),
        .btb_update(btb_update), .btb_pc_u(btb_pc_u), .btb_target_u(btb_target_u),
        .sweep_busy(sweep_busy), .sweep_done(sweep_done), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {logic [31:0] pc; logic [31:0] tgt;} ent_t;
    typedef struct packed {logic [31:0] pc; logic [31:0] tgt; logic done;} wr_t;

    // Reference model state
    ent_t        mq[$];
    bit          m_pref_dbg;
    bit          m_sweep;
    int          m_next;
    bit          e_upd, e_busy, e_done;
    logic [31:0] e_pc, e_tgt;
    int          e_drop;

    // Observation logs
    wr_t         wlog[$];
    int          n_dbg;
    int          n_busy;
    logic [31:0] mir_pc  [ENTRIES];
    logic [31:0] mir_tgt [ENTRIES];

    // Model + compare, all on the falling edge while inputs are stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs",
                {dbg_ready, btb_update, btb_pc_u, btb_target_u, sweep_busy, sweep_done, drop_cnt}, '0);
            mq.delete();
            m_pref_dbg = 0; m_sweep = 0; m_next = 0;
            e_upd = 0; e_busy = 0; e_done = 0; e_pc = 0; e_tgt = 0; e_drop = 0;
        end else begin
            int  sz;
            bit  n_upd, n_busy_e, n_done_e, e_rdy;
            logic [31:0] n_pc, n_tgt;
            ent_t h;
            chk("btb_update", btb_update, e_upd);
            if (e_upd) begin
                chk("btb_pc_u", btb_pc_u, e_pc);
                chk("btb_target_u", btb_target_u, e_tgt);
            end
            chk("sweep_busy", sweep_busy, e_busy);
            chk("sweep_done", sweep_done, e_done);
            chk("drop_cnt", drop_cnt, e_drop);

            if (btb_update) begin
                wlog.push_back('{btb_pc_u, btb_target_u, sweep_done});
                mir_pc[btb_pc_u[IDXW+1:2]]  = btb_pc_u;
                mir_tgt[btb_pc_u[IDXW+1:2]] = btb_target_u;
            end
            if (dbg_ready) n_dbg++;
            if (sweep_busy) n_busy++;

            sz = mq.size();
            n_upd = 0; n_busy_e = 0; n_done_e = 0; e_rdy = 0; n_pc = e_pc; n_tgt = e_tgt;
            if (flush_req) begin
                mq.delete();
                n_upd = 1; n_busy_e = 1; n_pc = 32'h1; n_tgt = 0;
                m_sweep = 1; m_next = 1;
            end else begin
                if (m_sweep) begin
                    n_upd = 1; n_busy_e = 1; n_pc = m_next * 4 + 1; n_tgt = 0;
                    if (m_next == ENTRIES - 1) begin
                        n_done_e = 1; m_sweep = 0;
                    end
                    m_next++;
                end else if (dbg_valid && (sz == 0 || m_pref_dbg)) begin
                    n_upd = 1; e_rdy = 1; n_pc = dbg_pc; n_tgt = dbg_target; m_pref_dbg = 0;
                end else if (sz > 0) begin
                    h = mq.pop_front();
                    n_upd = 1; n_pc = h.pc; n_tgt = h.tgt; m_pref_dbg = 1;
                end
                if (rs_valid && rs_taken) begin
                    if (sz >= DEPTH) begin
                        if (e_drop < 65535) e_drop++;
                    end else begin
                        mq.push_back('{rs_pc, rs_target});
                    end
                end
            end
            chk("dbg_ready", dbg_ready, e_rdy);
            e_upd = n_upd; e_pc = n_pc; e_tgt = n_tgt; e_busy = n_busy_e; e_done = n_done_e;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic resolve(input logic v, input logic t, input logic [31:0] pc, input logic [31:0] tg);
        rs_valid = v; rs_taken = t; rs_pc = pc; rs_target = tg;
    endtask

    function automatic int find_pc(input logic [31:0] pc);
        for (int i = 0; i < wlog.size(); i++) if (wlog[i].pc == pc) return i;
        return -1;
    endfunction

    logic [31:0] exp3 [12] = '{32'h800, 32'h10, 32'h800, 32'h14, 32'h800, 32'h18,
                               32'h800, 32'h1C, 32'h800, 32'h20, 32'h800, 32'h24};

    initial begin
        int ndone;
        #2 rst_n = 1'b0;
        ticks(3);
        rst_n = 1'b1;
        ticks(2);

        // 1: single taken resolve -> write two cycles later
        wlog.delete();
        resolve(1, 1, 32'h100, 32'h200);
        @(negedge clk); chk("t1_c0_upd", btb_update, 0);
        tick(); resolve(0, 0, 0, 0);
        @(negedge clk); chk("t1_c1_upd", btb_update, 0);
        tick();
        @(negedge clk);
        chk("t1_c2_upd", btb_update, 1);
        chk("t1_c2_pc", btb_pc_u, 32'h100);
        chk("t1_c2_tgt", btb_target_u, 32'h200);
        ticks(4);
        chk("t1_nwrites", wlog.size(), 1);

        // 2: not-taken resolve is ignored
        wlog.delete();
        resolve(1, 0, 32'h104, 32'h300);
        tick(); resolve(0, 0, 0, 0);
        ticks(5);
        chk("t2_nwrites", wlog.size(), 0);
        chk("t2_drop", drop_cnt, 0);

        // 3: resolves vs a held debug request, round-robin
        wlog.delete(); n_dbg = 0;
        dbg_valid = 1; dbg_pc = 32'h800; dbg_target = 32'h900;
        for (int i = 0; i < 6; i++) begin
            resolve(1, 1, 32'h10 + 4 * i, 32'h1000 + i);
            tick();
        end
        resolve(0, 0, 0, 0);
        ticks(6);
        dbg_valid = 0;
        ticks(4);
        chk("t3_nwrites", wlog.size(), 12);
        for (int i = 0; i < 12; i++)
            if (i < wlog.size()) chk($sformatf("t3_w%0d_pc", i), wlog[i].pc, exp3[i]);
        if (wlog.size() > 1) chk("t3_w1_tgt", wlog[1].tgt, 32'h1000);
        chk("t3_dbg_pulses", n_dbg, 6);
        chk("t3_drop", drop_cnt, 0);

        // 4: flush with 3 entries queued and debug pending
        wlog.delete(); n_busy = 0;
        dbg_valid = 1;
        for (int i = 0; i < 6; i++) begin
            resolve(1, 1, 32'h10 + 4 * i, 32'h1000 + i);
            tick();
        end
        resolve(0, 0, 0, 0);
        flush_req = 1;
        @(negedge clk); chk("t4_flush_dbg_ready", dbg_ready, 0);
        tick(); flush_req = 0;
        ticks(70);
        dbg_valid = 0;
        ticks(5);
        chk("t4_first_sentinel", find_pc(32'h1), 6);
        ndone = 0;
        for (int i = 0; i < wlog.size(); i++) if (wlog[i].done) ndone++;
        chk("t4_done_pulses", ndone, 1);
        if (wlog.size() > 70) begin
            chk("t4_last_pc", wlog[69].pc, 32'hFD);
            chk("t4_last_done", wlog[69].done, 1);
            chk("t4_after_sweep_dbg", wlog[70].pc, 32'h800);
        end else chk("t4_nwrites", wlog.size(), 71);
        chk("t4_busy_cycles", n_busy, 64);
        chk("t4_stale_1c", find_pc(32'h1C), -1);
        chk("t4_stale_24", find_pc(32'h24), -1);

        // 5a: resolves during sweep land after it; two are dropped
        wlog.delete();
        flush_req = 1; tick(); flush_req = 0;
        for (int i = 0; i < 6; i++) begin
            resolve(1, 1, 32'h40 + 4 * i, 32'h2000 + i);
            tick();
        end
        resolve(0, 0, 0, 0);
        ticks(70);
        chk("t5_nwrites", wlog.size(), 68);
        if (wlog.size() >= 68) begin
            chk("t5_w64_pc", wlog[64].pc, 32'h40);
            chk("t5_w67_pc", wlog[67].pc, 32'h4C);
        end
        chk("t5_drop", drop_cnt, 2);
        chk("t5_hit_40", mir_pc[16], 32'h40);
        chk("t5_hit_40_tgt", mir_tgt[16], 32'h2000);

        // 5b: re-flush at sweep idx 10 discards queued 0x40
        wlog.delete();
        flush_req = 1; tick(); flush_req = 0;
        tick();
        resolve(1, 1, 32'h40, 32'h2222); tick(); resolve(0, 0, 0, 0);
        ticks(7);
        flush_req = 1; tick(); flush_req = 0;
        ticks(80);
        chk("t5b_nwrites", wlog.size(), 74);
        if (wlog.size() >= 74) begin
            chk("t5b_w9_pc", wlog[9].pc, 32'h25);
            chk("t5b_restart_pc", wlog[10].pc, 32'h1);
            chk("t5b_last_pc", wlog[73].pc, 32'hFD);
        end
        chk("t5b_no_40", find_pc(32'h40), -1);
        chk("t5b_miss_40", mir_pc[16] == 32'h40, 0);

        // 6: saturate drop_cnt with the FIFO held full, then reset mid-sweep
        for (int k = 0; k < 72450; k++) begin
            resolve(1, 1, 32'h300, 32'h400);
            flush_req = (k % 63 == 0);
            tick();
        end
        resolve(0, 0, 0, 0); flush_req = 0;
        #2;
        chk("t6_drop_sat", drop_cnt, 16'hFFFF);
        chk("t6_busy_before_rst", sweep_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset",
            {btb_update, btb_pc_u, btb_target_u, sweep_busy, sweep_done, drop_cnt}, '0);
        ticks(3);
        rst_n = 1'b1;
        ticks(4);
        chk("t6_idle_after_reset", btb_update, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
